burst_mem_ctrl: RTL

Parametrised burst memory controller: the successor to the single-mode burst transaction block. It adds selectable FIXED/INCR/WRAP burst types, a programmable per-burst length, beat-level stalling, registered read data with a valid strobe, and protocol error reporting. It sits between a simple master (testbench or bus adapter) and an on-chip single-port RAM of 2**ADDR_WIDTH words owned by the block.

---
 rtl/burst_pkg.sv | 26 ++
 rtl/burst_addr_gen.sv | 31 +++
 rtl/burst_mem_ctrl.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/burst_pkg.sv
// Shared types and default sizing for the burst memory controller.
package burst_pkg;

    // Burst addressing modes; RSVD is decoded only to reject it.
    typedef enum logic [1:0] {
        FIXED = 2'b00,
        INCR  = 2'b01,
        WRAP  = 2'b10,
        RSVD  = 2'b11
    } burst_type_e;

    // Controller states.
    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_e;

    // Default geometry.
    localparam int DEF_ADDR_WIDTH = 5;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_MAX_BURST  = 16;

    // Largest wrapping burst the block supports, in beats.
    localparam int WRAP_MAX_BEATS = 16;

endpackage

// File: rtl/burst_addr_gen.sv
// Combinational next-beat address for FIXED, INCR and WRAP bursts.
// WRAP keeps the bits above the burst-length mask and increments only
// the bits under it, so the address cycles inside an aligned window.
module burst_addr_gen
    import burst_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int LEN_WIDTH  = $clog2(DEF_MAX_BURST)
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    input  burst_type_e           burst_type,
    input  logic [LEN_WIDTH-1:0]  burst_len,
    output logic [ADDR_WIDTH-1:0] next_addr
);

    logic [ADDR_WIDTH-1:0] incr_addr;
    logic [ADDR_WIDTH-1:0] wrap_mask;

    // Select the successor address according to the latched burst type.
    always_comb begin
        incr_addr = addr + ADDR_WIDTH'(1);
        wrap_mask = ADDR_WIDTH'(burst_len);
        next_addr = addr;
        case (burst_type)
            INCR:    next_addr = incr_addr;
            WRAP:    next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
            default: next_addr = addr;
        endcase
    end

endmodule

// File: rtl/burst_mem_ctrl.sv
// Burst memory controller: accepts a burst request in IDLE, then performs
// one RAM beat per cycle that beat_en is high until the programmed length
// is exhausted. Owns a 2**ADDR_WIDTH word single-port RAM.
//
// Request/beat protocol: start is sampled only while busy is low; a legal
// request is accepted on that edge (busy rises after it) and an illegal one,
// or any start while busy, produces a one-cycle err pulse without side
// effects. While busy, each edge with beat_en high consumes wr_data (write)
// or returns rd_data with rd_valid one cycle later (read); beat_en low is a
// stall. done pulses one cycle after the final beat, together with busy
// falling, and a new start may be presented in that same done cycle.
// busy is a registered copy of the FSM state (high exactly in BURST).
module burst_mem_ctrl
    import burst_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int MAX_BURST  = DEF_MAX_BURST,
    parameter int LEN_WIDTH  = $clog2(MAX_BURST)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [LEN_WIDTH-1:0]  burst_len,
    input  burst_type_e           burst_type,
    input  logic                  wren,
    input  logic                  rden,
    input  logic                  beat_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    state_e                state;
    logic [ADDR_WIDTH-1:0] addr;
    logic [LEN_WIDTH-1:0]  remaining;
    logic [LEN_WIDTH-1:0]  len_q;
    burst_type_e           type_q;
    logic                  is_write;

    logic [ADDR_WIDTH-1:0] next_addr;
    logic [LEN_WIDTH:0]    req_beats;
    logic                  wrap_ok;
    logic                  req_legal;
    logic                  beat;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    burst_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .LEN_WIDTH  (LEN_WIDTH)
    ) u_addr_gen (
        .addr       (addr),
        .burst_type (type_q),
        .burst_len  (len_q),
        .next_addr  (next_addr)
    );

    // Request legality: exactly one direction, known type, and a WRAP
    // length that is a power of two between 2 and the supported maximum.
    always_comb begin
        req_beats = {1'b0, burst_len} + {{LEN_WIDTH{1'b0}}, 1'b1};
        wrap_ok   = (burst_len != '0)
                 && ((req_beats & {1'b0, burst_len}) == '0)
                 && (int'(req_beats) <= WRAP_MAX_BEATS)
                 && (int'(req_beats) <= MAX_BURST);
        req_legal = (wren ^ rden)
                 && (burst_type != RSVD)
                 && ((burst_type != WRAP) || wrap_ok);
        beat      = (state == BURST) && beat_en;
    end

    // Control FSM with beat counter, address register and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            addr      <= '0;
            remaining <= '0;
            len_q     <= '0;
            type_q    <= FIXED;
            is_write  <= 1'b0;
            rd_data   <= '0;
            rd_valid  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (req_legal) begin
                            addr      <= start_addr;
                            remaining <= burst_len;
                            len_q     <= burst_len;
                            type_q    <= burst_type;
                            is_write  <= wren;
                            state     <= BURST;
                            busy      <= 1'b1;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                BURST: begin
                    if (start) begin
                        err <= 1'b1;
                    end
                    if (beat_en) begin
                        if (!is_write) begin
                            rd_data  <= mem[addr];
                            rd_valid <= 1'b1;
                        end
                        addr <= next_addr;
                        if (remaining == '0) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            remaining <= remaining - LEN_WIDTH'(1);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // RAM write port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (beat && is_write) begin
            mem[addr] <= wr_data;
        end
    end

endmodule
